// File: rtl/contador_seq_param_pkg.sv
// Shared definitions for the programmable-sequence counter: step direction
// codes, index/length width derivation and the reset contents of the table.
package contador_seq_param_pkg;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_BWD = 1'b1
  } dir_e;

  // A table of DEPTH entries needs at least one index bit even for tiny DEPTH.
  function automatic int seq_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Lengths run 1..DEPTH, so one extra bit over the index width is required.
  function automatic int seq_len_w(input int depth);
    return seq_addr_w(depth) + 1;
  endfunction

  function automatic int seq_reset_code(input int entry);
    return entry;
  endfunction

endpackage

// File: rtl/contador_seq_param_tabela.sv
// DEPTH x WIDTH code table with async reset to the identity sequence, one
// write port and a read port that forwards a same-cycle write to the same entry.
module contador_seq_tabela
  import contador_seq_param_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int AW    = seq_addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(seq_reset_code(i));
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = (we && (waddr == raddr)) ? wdata : mem_q[raddr];

endmodule

// File: rtl/contador_seq_param.sv
// Counter that steps forward/backward through a run-time loadable code table.
// Define CONTADOR_SEQ_CYCLES_EN to add the completed-sequence counter port 'cycles'.
module contador_seq_param
  import contador_seq_param_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int CYC_W = 8,
  localparam int AW   = seq_addr_w(DEPTH),
  localparam int LW   = seq_len_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             sync_clr,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             cfg_len_we,
  input  logic [LW-1:0]    cfg_len,
  output logic [WIDTH-1:0] q,
  output logic [AW-1:0]    idx,
`ifdef CONTADOR_SEQ_CYCLES_EN
  output logic [CYC_W-1:0] cycles,
`endif
  output logic             wrap,
  output logic             cfg_err
);

  logic [LW-1:0]    len_q,  len_d;
  logic [AW-1:0]    idx_q,  idx_d;
  logic [WIDTH-1:0] q_q,    q_d;
  logic             wrap_q, wrap_d;
  logic             err_q,  err_d;
  logic             loadQ;
  logic             lenOk;
  logic             addrOk;
  logic             tableWe;
  logic [AW-1:0]    lastIdx;
  logic [WIDTH-1:0] tableRd;

  // With a power-of-two DEPTH every address is a real entry.
  if (DEPTH == (1 << AW)) begin : gen_addr_full
    assign addrOk = 1'b1;
  end else begin : gen_addr_check
    assign addrOk = (32'(cfg_addr) < 32'(DEPTH));
  end

  assign lenOk   = (cfg_len != '0) && (cfg_len <= LW'(DEPTH));
  assign tableWe = cfg_we && addrOk;
  assign lastIdx = AW'(len_q - LW'(1));

  contador_seq_tabela #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_tabela (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tableWe),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_d),
    .rdata (tableRd)
  );

  always_comb begin
    len_d  = len_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    loadQ  = 1'b0;
    err_d  = cfg_we && !addrOk;
    if (sync_clr) begin
      idx_d = '0;
      loadQ = 1'b1;
    end else if (cfg_len_we) begin
      if (lenOk) begin
        len_d = cfg_len;
        if ({1'b0, idx_q} >= cfg_len) begin
          idx_d = '0;
          loadQ = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      loadQ = 1'b1;
      if (dir == DIR_FWD) begin
        if (idx_q == lastIdx) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end else begin
        if (idx_q == '0) begin
          idx_d  = lastIdx;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q - AW'(1);
        end
      end
    end
    q_d = loadQ ? tableRd : q_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= LW'(DEPTH);
      idx_q  <= '0;
      q_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      len_q  <= len_d;
      idx_q  <= idx_d;
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q       = q_q;
  assign idx     = idx_q;
  assign wrap    = wrap_q;
  assign cfg_err = err_q;

`ifdef CONTADOR_SEQ_CYCLES_EN
  logic [CYC_W-1:0] cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= '0;
    end else if (sync_clr) begin
      cycles_q <= '0;
    end else if (wrap_d) begin
      cycles_q <= cycles_q + CYC_W'(1);
    end
  end

  assign cycles = cycles_q;
`else
  logic unusedCycW;
  assign unusedCycW = (CYC_W > 0);
`endif

endmodule

// File: tb/tb_contador_seq_param.sv
// Directed self-checking bench for contador_seq_param; the cycle-counter
// section only runs when CONTADOR_SEQ_CYCLES_EN is defined.
module tb_contador_seq_param;

  localparam int WIDTH = 3;
  localparam int DEPTH = 8;
  localparam int CYC_W = 8;
  localparam int AW    = 3;
  localparam int LW    = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             dir;
  logic             sync_clr;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic             cfg_len_we;
  logic [LW-1:0]    cfg_len;
  logic [WIDTH-1:0] q;
  logic [AW-1:0]    idx;
  logic             wrap;
  logic             cfg_err;
`ifdef CONTADOR_SEQ_CYCLES_EN
  logic [CYC_W-1:0] cycles;
`endif

  int checks   = 0;
  int failures = 0;

  contador_seq_param #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CYC_W (CYC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .dir        (dir),
    .sync_clr   (sync_clr),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_len_we (cfg_len_we),
    .cfg_len    (cfg_len),
    .q          (q),
    .idx        (idx),
`ifdef CONTADOR_SEQ_CYCLES_EN
    .cycles     (cycles),
`endif
    .wrap       (wrap),
    .cfg_err    (cfg_err)
  );

  // Free-running clock; inputs change and outputs are sampled 1ns after each rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge with the given en/dir/sync_clr plus whatever cfg strobes were preset.
  task automatic applyStimulus(input logic enV, input logic dirV, input logic clrV);
    en       = enV;
    dir      = dirV;
    sync_clr = clrV;
    @(posedge clk);
    #1;
    en         = 1'b0;
    sync_clr   = 1'b0;
    cfg_we     = 1'b0;
    cfg_len_we = 1'b0;
  endtask

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input int expQ, input int expIdx, input int expWrap);
    checkOutput({tag, ".q"}, 32'(q), expQ);
    checkOutput({tag, ".idx"}, 32'(idx), expIdx);
    checkOutput({tag, ".wrap"}, 32'(wrap), expWrap);
  endtask

  // Whole directed sequence; expected values are worked out by hand from the table contents.
  initial begin
    int loadVals [5] = '{1, 7, 0, 2, 3};
    int fwdQ     [5] = '{7, 0, 2, 3, 1};
    int fwdIdx   [5] = '{1, 2, 3, 4, 0};
    int fwdWrap  [5] = '{0, 0, 0, 0, 1};
    int bwdQ     [5] = '{3, 2, 0, 7, 1};
    int bwdIdx   [5] = '{4, 3, 2, 1, 0};
    int bwdWrap  [5] = '{1, 0, 0, 0, 0};

    rst_n      = 1'b0;
    en         = 1'b0;
    dir        = 1'b0;
    sync_clr   = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    cfg_len_we = 1'b0;
    cfg_len    = '0;
    #12;
    checkState("reset", 0, 0, 0);
    checkOutput("reset.cfg_err", 32'(cfg_err), 0);
`ifdef CONTADOR_SEQ_CYCLES_EN
    checkOutput("reset.cycles", 32'(cycles), 0);
`endif
    rst_n = 1'b1;

    $display("[TB] loading table 1,7,0,2,3 and len=5");
    for (int a = 0; a < 5; a++) begin
      cfg_we   = 1'b1;
      cfg_addr = AW'(a);
      cfg_data = WIDTH'(loadVals[a]);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkState("stale_after_load", 0, 0, 0);
    cfg_len_we = 1'b1;
    cfg_len    = LW'(5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("len5_hold", 0, 0, 0);
    checkOutput("len5.cfg_err", 32'(cfg_err), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkState("clr1", 1, 0, 0);

    $display("[TB] forward sequence");
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkState($sformatf("fwd%0d", s), fwdQ[s], fwdIdx[s], fwdWrap[s]);
    end

    $display("[TB] backward sequence");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkState("clr2", 1, 0, 0);
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkState($sformatf("bwd%0d", s), bwdQ[s], bwdIdx[s], bwdWrap[s]);
    end

    $display("[TB] length changes");
    for (int s = 0; s < 4; s++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("at_idx4", 3, 4, 0);
    cfg_len_we = 1'b1;
    cfg_len    = LW'(3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("len3_shrink", 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("len3_step2", 0, 2, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("len3_wrap", 1, 0, 1);
    cfg_len_we = 1'b1;
    cfg_len    = LW'(0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("len0.cfg_err", 32'(cfg_err), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("err_pulse_end", 32'(cfg_err), 0);
    cfg_len_we = 1'b1;
    cfg_len    = LW'(9);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("len9.cfg_err", 32'(cfg_err), 1);
    checkOutput("len9.idx", 32'(idx), 0);
    for (int s = 0; s < 3; s++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("len_kept3", 1, 0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    cfg_len_we = 1'b1;
    cfg_len    = LW'(5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("len5_grow_hold", 0, 2, 0);

    $display("[TB] write-through and clear priority");
    applyStimulus(1'b0, 1'b0, 1'b1);
    cfg_we   = 1'b1;
    cfg_addr = AW'(1);
    cfg_data = WIDTH'(6);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("write_through", 6, 1, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkState("back_to0", 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("reread1", 6, 1, 0);
    cfg_len_we = 1'b1;
    cfg_len    = LW'(2);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkState("clr_wins", 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("len_not_2", 0, 2, 0);
    cfg_we   = 1'b1;
    cfg_addr = AW'(2);
    cfg_data = WIDTH'(5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("stale_write", 0, 2, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkState("stale_refresh", 5, 2, 0);

    $display("[TB] asynchronous reset mid-run");
    rst_n = 1'b0;
    #2;
    checkState("async_rst", 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("rst_tab1", 1, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("rst_tab2", 2, 2, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkState("rst_len8", 7, 7, 1);

    $display("[TB] length one");
    cfg_len_we = 1'b1;
    cfg_len    = LW'(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("len1_set", 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("len1_fwd", 0, 0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkState("len1_bwd", 0, 0, 1);

`ifdef CONTADOR_SEQ_CYCLES_EN
    $display("[TB] completed-cycle counter");
    cfg_len_we = 1'b1;
    cfg_len    = LW'(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("cycles_clr", 32'(cycles), 0);
    for (int s = 0; s < 600; s++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cycles_600", 32'(cycles), 44);
    checkOutput("cycles_idx", 32'(idx), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
